ireg_wb_sched: RTL

- Write-port scheduler and scoreboard for the integer register file.
- Shares the single register-file write port between two writers:
  - the fixed-latency ALU pipeline;
  - a long-latency unit (load/divide) with a valid/ready return handshake.
- Tracks registers with pending long-latency results and stalls decode on RAW/WAW hazards against them.
- Sits between decode, the execute stages and the register file write port.

---
 rtl/ireg_wb_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ireg_wb_sched.sv
// Integer register-file write-port scheduler and long-latency scoreboard.
// Arbitrates ALU vs long unit onto one registered write port; stalls decode on hazards.
module ireg_wb_sched #(
    parameter int MAX_OUTST = 4,
    parameter int MAX_WAIT  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_v,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_rd_v,
    input  logic        dec_long,
    output logic        stall,
    input  logic        alu_v,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_hold,
    input  logic        lu_v,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        wr_v,
    output logic [4:0]  wr_rd,
    output logic [31:0] wr_data,
    output logic [31:0] busy,
    output logic        err
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt;
    logic [WW-1:0] wcnt;
    logic          full;
    logic          force_lu;
    logic          issue;
    logic          alu_acc;
    logic          lu_xfer;
    logic [31:0]   set_vec;
    logic [31:0]   clr_vec;
    logic [31:0]   busy_nxt;
    logic          wsel_v;
    logic [4:0]    wsel_rd;
    logic [31:0]   wsel_data;

    function automatic logic haz(input logic [4:0] r, input logic [31:0] b);
        return (r != 5'd0) && b[r];
    endfunction

    // Hazard detection and write-port arbitration
    always_comb begin
        full     = (cnt == CW'(MAX_OUTST));
        force_lu = lu_v & (wcnt == WW'(MAX_WAIT));
        stall    = dec_v & (haz(dec_rs1, busy) | haz(dec_rs2, busy)
                 | (dec_rd_v & haz(dec_rd, busy)) | (dec_long & full));
        issue    = dec_v & ~stall & dec_long;
        alu_hold = alu_v & force_lu;
        lu_ready = ~alu_v | force_lu;
        alu_acc  = alu_v & ~force_lu;
        lu_xfer  = lu_v & lu_ready;
    end

    // Scoreboard next state: clear on return, set on issue
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (lu_xfer)
            clr_vec[lu_rd] = 1'b1;
        if (issue && dec_rd_v)
            set_vec[dec_rd] = 1'b1;
        busy_nxt    = (busy & ~clr_vec) | set_vec;
        busy_nxt[0] = 1'b0;
    end

    // Select the accepted writer for the registered write port
    always_comb begin
        wsel_v    = 1'b0;
        wsel_rd   = wr_rd;
        wsel_data = wr_data;
        unique case (1'b1)
            alu_acc: begin
                wsel_v    = (alu_rd != 5'd0);
                wsel_rd   = alu_rd;
                wsel_data = alu_data;
            end
            lu_xfer: begin
                wsel_v    = (lu_rd != 5'd0);
                wsel_rd   = lu_rd;
                wsel_data = lu_data;
            end
            default: ;
        endcase
    end

    // Scoreboard, outstanding counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (issue && !lu_xfer)
                cnt <= cnt + CW'(1);
            else if (!issue && lu_xfer && cnt != '0)
                cnt <= cnt - CW'(1);
            if (lu_xfer && lu_rd != 5'd0 && !busy[lu_rd])
                err <= 1'b1;
        end
    end

    // Starvation counter for the long unit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wcnt <= '0;
        else if (lu_xfer || !lu_v)
            wcnt <= '0;
        else if (wcnt != WW'(MAX_WAIT))
            wcnt <= wcnt + WW'(1);
    end

    // Registered write port; address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_v    <= 1'b0;
            wr_rd   <= '0;
            wr_data <= '0;
        end else begin
            wr_v    <= wsel_v;
            wr_rd   <= wsel_rd;
            wr_data <= wsel_data;
        end
    end

endmodule
